// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl -- transaction sequencer in front of spi_master.
//
// Accepts one command (byte count + slave index), drives the selected
// active-low slave select with setup / hold / inter-frame gap timing, feeds
// write bytes one at a time into spi_master and returns each received byte.
// A watchdog aborts a transfer whose byte does not come back in time.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_len                       bytes to transfer (0 = 256)
//   cmd_ss                        slave index
//   wr_data/wr_valid/wr_ready     write byte stream from requester
//   rd_data/rd_valid              received byte strobe (no backpressure)
//   busy, done, err               status; done/err are one-cycle pulses
//   ss_n                          active-low slave selects
//   spi_tx_*                      byte to spi_master
//   spi_rx_*                      byte from spi_master
module spi_xfer_ctrl #(
  parameter int NUM_SS   = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8,
  parameter int TIMEOUT  = 1024,
  localparam int SSW     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_len,
  input  logic [SSW-1:0]    cmd_ss,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM_SS-1:0] ss_n,
  output logic [7:0]        spi_tx_data,
  output logic              spi_tx_valid,
  input  logic              spi_tx_ready,
  input  logic [7:0]        spi_rx_data,
  input  logic              spi_rx_valid
);

  localparam int TMAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TMAX  = (TMAX0 > CS_GAP) ? TMAX0 : CS_GAP;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int WDW   = $clog2(TIMEOUT + 1);

  localparam logic [SSW:0]        NSS = NUM_SS[SSW:0];
  localparam logic [NUM_SS-1:0]   ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_SEND, S_WAIT_RX, S_HOLD, S_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [WDW-1:0]    wd, wd_nxt;
  logic [8:0]        cnt, cnt_nxt;
  logic              abort, abort_nxt;
  logic [NUM_SS-1:0] ss_n_nxt;
  logic [7:0]        tx_data_nxt, rd_data_nxt;
  logic              tx_valid_nxt, rd_valid_nxt, done_nxt, err_nxt, wr_ready_nxt;
  logic              ss_ok, wd_expired;

  assign cmd_ready  = (state == S_IDLE) && !rst;
  assign busy       = (state != S_IDLE);
  assign ss_ok      = ({1'b0, cmd_ss} < NSS);
  // The watchdog runs across SEND and WAIT_RX without restarting, so the
  // budget covers the whole byte round trip.
  assign wd_expired = (wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = (timer != '0) ? timer - TW'(1) : timer;
    wd_nxt       = wd;
    cnt_nxt      = cnt;
    abort_nxt    = abort;
    ss_n_nxt     = ss_n;
    tx_data_nxt  = spi_tx_data;
    tx_valid_nxt = spi_tx_valid;
    rd_data_nxt  = rd_data;
    rd_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_valid) begin
        cnt_nxt = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
        if (ss_ok) begin
          ss_n_nxt  = ~(ONE << cmd_ss);
          timer_nxt = TW'(CS_SETUP - 1);
          state_nxt = S_SETUP;
        end else begin
          // Bad slave index: finish immediately with an error, never select.
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          timer_nxt = TW'(CS_GAP);
          state_nxt = S_GAP;
        end
      end
      S_SETUP: if (timer == '0) state_nxt = S_FETCH;
      S_FETCH: if (wr_valid) begin
        tx_data_nxt  = wr_data;
        tx_valid_nxt = 1'b1;
        wd_nxt       = '0;
        state_nxt    = S_SEND;
      end
      S_SEND: begin
        wd_nxt = wd + WDW'(1);
        // rx_valid is deliberately not looked at here: a byte cannot be
        // returned before it has been handed over.
        if (spi_tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = S_WAIT_RX;
        end else if (wd_expired) begin
          tx_valid_nxt = 1'b0;
          abort_nxt    = 1'b1;
          timer_nxt    = TW'(CS_HOLD - 1);
          state_nxt    = S_HOLD;
        end
      end
      S_WAIT_RX: begin
        wd_nxt = wd + WDW'(1);
        // A byte arriving on the expiry cycle still counts as delivered.
        if (spi_rx_valid) begin
          rd_data_nxt  = spi_rx_data;
          rd_valid_nxt = 1'b1;
          cnt_nxt      = cnt - 9'd1;
          if (cnt == 9'd1) begin
            timer_nxt = TW'(CS_HOLD - 1);
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_FETCH;
          end
        end else if (wd_expired) begin
          abort_nxt = 1'b1;
          timer_nxt = TW'(CS_HOLD - 1);
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: if (timer == '0) begin
        ss_n_nxt  = '1;
        done_nxt  = 1'b1;
        err_nxt   = abort;
        // GAP spans CS_GAP+1 cycles so cmd_ready returns CS_GAP+1 after done.
        timer_nxt = TW'(CS_GAP);
        state_nxt = S_GAP;
      end
      S_GAP: if (timer == '0) begin
        abort_nxt = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    wr_ready_nxt = (state_nxt == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      wd           <= '0;
      cnt          <= '0;
      abort        <= 1'b0;
      ss_n         <= '1;
      spi_tx_data  <= '0;
      spi_tx_valid <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      wr_ready     <= 1'b0;
    end else begin
      timer        <= timer_nxt;
      wd           <= wd_nxt;
      cnt          <= cnt_nxt;
      abort        <= abort_nxt;
      ss_n         <= ss_n_nxt;
      spi_tx_data  <= tx_data_nxt;
      spi_tx_valid <= tx_valid_nxt;
      rd_data      <= rd_data_nxt;
      rd_valid     <= rd_valid_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
      wr_ready     <= wr_ready_nxt;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a loopback spi_master model plus
// table-driven transfers and hand-written corner-case sequences.
module tb_spi_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: NUM_SS=4, TIMEOUT=64
  logic       cmd_valid = 0, cmd_ready, wr_valid = 0, wr_ready;
  logic [7:0] cmd_len = 0, wr_data = 0, rd_data, spi_tx_data;
  logic [1:0] cmd_ss = 0;
  logic       rd_valid, busy, done, err, spi_tx_valid;
  logic [3:0] ss_n;
  logic       spi_tx_ready, spi_rx_valid;
  logic [7:0] spi_rx_data;

  spi_xfer_ctrl #(.NUM_SS(4), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_ss(cmd_ss), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .err(err), .ss_n(ss_n), .spi_tx_data(spi_tx_data),
    .spi_tx_valid(spi_tx_valid), .spi_tx_ready(spi_tx_ready),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid));

  // second DUT: NUM_SS=3 for the invalid-slave case
  logic       cmd_valid3 = 0, cmd_ready3, wr_ready3, rd_valid3, busy3, done3, err3, tx_valid3;
  logic [7:0] rd_data3, tx_data3;
  logic [1:0] cmd_ss3 = 0;
  logic [2:0] ss_n3;

  spi_xfer_ctrl #(.NUM_SS(3), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(8), .TIMEOUT(64)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_len(8'd1), .cmd_ss(cmd_ss3), .wr_data(8'd0), .wr_valid(1'b0),
    .wr_ready(wr_ready3), .rd_data(rd_data3), .rd_valid(rd_valid3), .busy(busy3),
    .done(done3), .err(err3), .ss_n(ss_n3), .spi_tx_data(tx_data3),
    .spi_tx_valid(tx_valid3), .spi_tx_ready(1'b0),
    .spi_rx_data(8'd0), .spi_rx_valid(1'b0));

  // loopback spi_master model: accept a byte, echo it a few cycles later
  logic       stall = 0;
  int         m_st, m_dly;
  logic [7:0] m_data;
  always @(posedge clk) begin
    spi_tx_ready <= 1'b0;
    spi_rx_valid <= 1'b0;
    if (rst) begin
      m_st        <= 0;
      spi_rx_data <= 8'd0;
    end else if (m_st == 0) begin
      if (spi_tx_valid && !stall) begin
        spi_tx_ready <= 1'b1;
        m_data       <= spi_tx_data;
        m_dly        <= 2;
        m_st         <= 1;
      end
    end else if (m_dly == 0) begin
      spi_rx_valid <= 1'b1;
      spi_rx_data  <= m_data;
      m_st         <= 0;
    end else begin
      m_dly <= m_dly - 1;
    end
  end

  // monitors (sampled on the falling edge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_done = 0, n_err = 0, n_err_lone = 0, n_tx = 0, n_rd = 0, n_ss_rel = 0;
  int         rd_last = 0, t_tx_first = 0;
  logic [3:0] ss_at_tx = 0;
  logic       first_pend = 0, prev_low = 0, prev_txv = 0;
  logic [7:0] rd_q[$];
  int         done_t[$], sslo_t[$], sshi_t[$], txr_t[$], txf_t[$], hs_t[$];
  int         n_done3 = 0, n_err3 = 0, ss3_low = 0, t_done3 = 0, t_cmd3 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if ((ss_n != 4'hF) && !prev_low) begin sslo_t.push_back(cyc); first_pend = 1; end
      if ((ss_n == 4'hF) && prev_low)  begin sshi_t.push_back(cyc); n_ss_rel++; end
      if (spi_tx_valid && !prev_txv) begin
        txr_t.push_back(cyc);
        if (first_pend) begin t_tx_first = cyc; ss_at_tx = ss_n; first_pend = 0; end
      end
      if (!spi_tx_valid && prev_txv) txf_t.push_back(cyc);
      if (spi_tx_valid && spi_tx_ready) n_tx++;
      if (rd_valid) begin rd_q.push_back(rd_data); rd_last = cyc; n_rd++; end
      if (done) begin n_done++; done_t.push_back(cyc); end
      if (err) begin n_err++; if (!done) n_err_lone++; end
      if (cmd_valid && cmd_ready) hs_t.push_back(cyc);
      if (done3) begin n_done3++; t_done3 = cyc; end
      if (err3) n_err3++;
      if (ss_n3 != 3'b111) ss3_low++;
      if (cmd_valid3 && cmd_ready3) t_cmd3 = cyc;
    end
    prev_low = (ss_n != 4'hF);
    prev_txv = spi_tx_valid;
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_ge(input string nm, input longint act, input longint lim);
    tests++;
    if (act < lim) begin
      fails++;
      $display("FAIL %s: got %0d, expected >= %0d", nm, act, lim);
    end
  endtask

  task automatic issue_cmd(input int len, input int ss);
    int k = 0;
    cmd_len = len[7:0]; cmd_ss = ss[1:0]; cmd_valid = 1'b1;
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    if (!cmd_ready) check("cmd_ready_wait", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    wr_data = b; wr_valid = 1'b1;
    while (!wr_ready && k < 300) begin @(negedge clk); k++; end
    if (!wr_ready) begin
      check("wr_ready_wait", 0, 1);
      wr_valid = 1'b0;
      return;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int k = 0;
    while (n_done < target && k < bound) begin @(negedge clk); k++; end
  endtask

  logic [7:0] wbuf [256];

  task automatic xfer(input string nm, input int len, input int ss,
                      input logic [3:0] exp_ssn, input int pause_at);
    int n, d0, e0, tx0, rel0, bad;
    n = (len == 0) ? 256 : len;
    d0 = n_done; e0 = n_err; tx0 = n_tx; rel0 = n_ss_rel; bad = 0;
    rd_q.delete();
    issue_cmd(len, ss);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        repeat (50) @(negedge clk);
        check({nm, "_pause_wr_ready"}, wr_ready, 1);
        check({nm, "_pause_ss_n"}, ss_n, exp_ssn);
      end
      send_byte(wbuf[i]);
    end
    wait_done(d0 + 1, 200);
    @(negedge clk);
    check({nm, "_done"}, n_done - d0, 1);
    check({nm, "_err"}, n_err - e0, 0);
    check({nm, "_rd_cnt"}, rd_q.size(), n);
    for (int i = 0; i < n && i < rd_q.size(); i++)
      if (rd_q[i] != wbuf[i]) begin
        if (bad == 0) $display("FAIL %s_rd_data[%0d]: got %0h, expected %0h", nm, i, rd_q[i], wbuf[i]);
        bad++;
      end
    check({nm, "_rd_bad_bytes"}, bad, 0);
    check({nm, "_tx_hs"}, n_tx - tx0, n);
    check({nm, "_ss_releases"}, n_ss_rel - rel0, 1);
    check({nm, "_ss_sel"}, ss_at_tx, exp_ssn);
    check_ge({nm, "_setup"}, t_tx_first - sslo_t[$], 4);
    check({nm, "_hold"}, sshi_t[$] - rd_last, 4);
    check({nm, "_done_at_release"}, done_t[$], sshi_t[$]);
    check({nm, "_ss_idle"}, ss_n, 4'hF);
  endtask

  typedef struct {
    int         len;
    int         ss;
    logic [7:0] base;
    logic [7:0] step;
    logic [3:0] exp_ssn;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0, e0, rd0, lone0, h0;

    vecs[0] = '{1, 2, 8'h55, 8'h00, 4'b1011};
    vecs[1] = '{2, 0, 8'h10, 8'h01, 4'b1110};
    vecs[2] = '{5, 1, 8'hF0, 8'h03, 4'b1101};
    vecs[3] = '{4, 3, 8'h00, 8'h11, 4'b0111};
    vecs[4] = '{7, 2, 8'h81, 8'h25, 4'b1011};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ss_n", ss_n, 4'hF);
    check("rst_tx_valid", spi_tx_valid, 0);
    check("rst_tx_data", spi_tx_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // table-driven transfers
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].len; i++) wbuf[i] = vecs[v].base + vecs[v].step * 8'(i);
      xfer($sformatf("vec%0d", v), vecs[v].len, vecs[v].ss, vecs[v].exp_ssn, -1);
    end

    // 3-byte burst
    wbuf[0] = 8'hA3; wbuf[1] = 8'hAA; wbuf[2] = 8'h0F;
    xfer("burst3", 3, 2, 4'b1011, -1);

    // 256 bytes with a 50-cycle stall in the write stream
    for (int i = 0; i < 256; i++) wbuf[i] = 8'(i);
    xfer("len256", 0, 2, 4'b1011, 100);

    // back-to-back commands with cmd_valid held high
    rd_q.delete();
    d0 = n_done; h0 = hs_t.size();
    cmd_len = 8'd1; cmd_ss = 2'd0; cmd_valid = 1'b1;
    send_byte(8'hC1);
    send_byte(8'hC2);
    cmd_valid = 1'b0;
    wait_done(d0 + 2, 300);
    @(negedge clk);
    check("b2b_done", n_done - d0, 2);
    check("b2b_hs", hs_t.size() - h0, 2);
    if (hs_t.size() >= h0 + 2 && done_t.size() >= d0 + 1)
      check("b2b_hs_gap", hs_t[h0 + 1] - done_t[d0], 9);
    check_ge("b2b_ss_high", sslo_t[$] - sshi_t[$ - 1], 8);
    check("b2b_rd_cnt", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("b2b_rd0", rd_q[0], 8'hC1);
      check("b2b_rd1", rd_q[1], 8'hC2);
    end

    // watchdog timeout: spi_master never accepts the byte
    stall = 1'b1;
    d0 = n_done; e0 = n_err; rd0 = n_rd; lone0 = n_err_lone;
    issue_cmd(2, 3);
    send_byte(8'h3C);
    wait_done(d0 + 1, 200);
    @(negedge clk);
    check("to_done", n_done - d0, 1);
    check("to_err", n_err - e0, 1);
    check("to_err_with_done", n_err_lone - lone0, 0);
    check("to_rd_none", n_rd - rd0, 0);
    check("to_ss_sel", ss_at_tx, 4'b0111);
    check("to_done_time", done_t[$] - txr_t[$], 68);
    check("to_txv_drop", txf_t[$] - txr_t[$], 64);
    check("to_ss_n", ss_n, 4'hF);
    stall = 1'b0;

    // invalid slave on the 3-select instance
    cmd_ss3 = 2'd3; cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    repeat (12) @(negedge clk);
    check("inv_done", n_done3, 1);
    check("inv_err", n_err3, 1);
    check("inv_done_time", t_done3 - t_cmd3, 1);
    check("inv_ss_never_low", ss3_low, 0);
    check("inv_ss_n", ss_n3, 3'b111);

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++) wbuf[i] = 8'h60 + 8'(i);
    issue_cmd(5, 1);
    send_byte(wbuf[0]);
    send_byte(wbuf[1]);
    send_byte(wbuf[2]);
    check("mid_pre_txv", spi_tx_valid, 1);
    d0 = n_done; e0 = n_err;
    rst = 1'b1;
    @(negedge clk);
    check("mid_ss_n", ss_n, 4'hF);
    check("mid_txv", spi_tx_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_wr_ready", wr_ready, 0);
    check("mid_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_no_done", n_done - d0, 0);
    check("mid_no_err", n_err - e0, 0);

    // recovery after reset
    for (int i = 0; i < 2; i++) wbuf[i] = 8'h9A ^ 8'(i);
    xfer("after_rst", 2, 3, 4'b0111, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation time limit, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
